// File: rtl/io_halfduplex_ctrl_if.sv
// Command/response channel of the half-duplex pad controller.
interface io_halfduplex_ctrl_if #(parameter int DW = 8);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rd;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_rd, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/io_halfduplex_ctrl.sv
// Half-duplex pad controller: serial drive bursts on io, hi-Z turnaround,
// optional read-back sampling, and drive-contention detection.
module io_halfduplex_ctrl #(
    parameter int DW = 8,
    parameter int TA = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_halfduplex_ctrl_if.slave  bus,
    inout  wire                  io,
    output logic                 io_oe,
    output logic                 conflict,
    output logic                 conflict_sts
);
    localparam int CW = $clog2((DW > TA ? DW : TA) + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, TA_OUT, SAMPLE, TA_IN, RSP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] sh;
    logic [DW-1:0] rx;
    logic          rd;
    logic          io_out;

    // io_oe resets asynchronously, so the pad is released without a clock.
    assign io           = io_oe ? io_out : 1'bz;
    assign bus.rsp_data = rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sh            <= '0;
            rx            <= '0;
            rd            <= 1'b0;
            io_out        <= 1'b0;
            io_oe         <= 1'b0;
            conflict      <= 1'b0;
            conflict_sts  <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
        end else begin
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        sh            <= {bus.cmd_data[DW-2:0], 1'b0};
                        io_out        <= bus.cmd_data[DW-1];
                        io_oe         <= 1'b1;
                        rd            <= bus.cmd_rd;
                        conflict_sts  <= 1'b0;
                        bus.cmd_ready <= 1'b0;
                        cnt           <= '0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Case-inequality so an X/Z net in simulation also flags contention.
                    if (io !== io_out) begin
                        conflict     <= 1'b1;
                        conflict_sts <= 1'b1;
                    end
                    if (cnt == CW'(DW-1)) begin
                        cnt   <= '0;
                        io_oe <= 1'b0;
                        state <= rd ? TA_OUT : TA_IN;
                    end else begin
                        cnt    <= cnt + CW'(1);
                        io_out <= sh[DW-1];
                        sh     <= {sh[DW-2:0], 1'b0};
                    end
                end
                TA_OUT: begin
                    if (cnt == CW'(TA-1)) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SAMPLE: begin
                    rx <= {rx[DW-2:0], (io === 1'b1)};
                    if (cnt == CW'(DW-1)) begin
                        cnt   <= '0;
                        state <= TA_IN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TA_IN: begin
                    if (cnt == CW'(TA-1)) begin
                        cnt <= '0;
                        if (rd) begin
                            bus.rsp_valid <= 1'b1;
                            state         <= RSP;
                        end else begin
                            bus.cmd_ready <= 1'b1;
                            state         <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_halfduplex_ctrl.sv
// Directed bench for io_halfduplex_ctrl with a cycle-timeline reference model.
module tb_io_halfduplex_ctrl;
    localparam int DW = 8;
    localparam int TA = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic io_oe, conflict, conflict_sts;
    logic tb_en, tb_val;
    wire  io;

    io_halfduplex_ctrl_if #(.DW(DW)) bus();

    assign io = tb_en ? tb_val : 1'bz;

    io_halfduplex_ctrl #(.DW(DW), .TA(TA)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .io(io),
        .io_oe(io_oe), .conflict(conflict), .conflict_sts(conflict_sts)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int conf_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference timeline: j = edges since the accept edge; cycle j+1 follows edge j.
    int            ecnt = 0;
    int            t0   = 0;
    bit            m_busy = 0, m_rd = 0, m_rsp = 0, m_conf = 0, m_sts = 0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_rx   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_rsp = 0; m_conf = 0; m_sts = 0; m_rx = '0;
        end else begin
            automatic int j;
            ecnt++;
            j = ecnt - t0;
            m_conf = 0;
            if (m_busy) begin
                if (j >= 1 && j <= DW) begin
                    if (tb_en && (tb_val !== m_data[DW-j])) begin
                        m_conf = 1;
                        m_sts  = 1;
                    end
                end
                if (m_rd && j >= DW+TA+1 && j <= 2*DW+TA)
                    m_rx = {m_rx[DW-2:0], (tb_en && tb_val === 1'b1)};
                if (!m_rd && j == DW+TA)
                    m_busy = 0;
                if (m_rsp) begin
                    if (bus.rsp_ready) begin
                        m_rsp  = 0;
                        m_busy = 0;
                    end
                end else if (m_rd && j == 2*DW+2*TA) begin
                    m_rsp = 1;
                end
            end else if (bus.cmd_valid) begin
                m_busy = 1;
                t0     = ecnt;
                m_rd   = bus.cmd_rd;
                m_data = bus.cmd_data;
                m_sts  = 0;
            end
        end
    end

    always @(negedge clk) begin
        automatic int j   = ecnt - t0;
        automatic bit e_oe = m_busy && j >= 0 && j < DW;
        chk("cmd_ready", bus.cmd_ready, !m_busy);
        chk("io_oe", io_oe, e_oe);
        if (e_oe && !tb_en) chk("io_bit", io, m_data[DW-1-j]);
        chk("rsp_valid", bus.rsp_valid, m_rsp);
        chk("rsp_data", bus.rsp_data, m_rx);
        chk("conflict", conflict, m_conf);
        chk("conflict_sts", conflict_sts, m_sts);
        if (conflict === 1'b1) conf_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issued in an idle cycle; returns one tick into cycle 1 of the transfer.
    task automatic send(input bit rd, input logic [DW-1:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = rd;
        bus.cmd_data  = d;
        step(1);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h5A;
    endtask

    task automatic drive_pattern(input logic [DW-1:0] pat);
        for (int i = 0; i < DW; i++) begin
            tb_en  = 1'b1;
            tb_val = pat[DW-1-i];
            step(1);
        end
        tb_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tb_en = 1'b0; tb_val = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_rd = 1'b0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
        step(2);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_io_oe", io_oe, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        rst_n = 1'b1;
        step(1);

        // Write 0xA5 on an otherwise undriven net.
        conf_seen = 0;
        send(0, 8'hA5);
        chk("wr_first_bit", io, 1);
        step(10);
        chk("wr_ready_c11", bus.cmd_ready, 1);
        chk("wr_no_conflict", conf_seen, 0);

        // Read: bench returns 0x96 in cycles 11..18.
        send(1, 8'h3C);
        step(10);
        drive_pattern(8'h96);
        chk("rd_released_c19", io_oe, 0);
        step(2);
        chk("rd_valid_c21", bus.rsp_valid, 1);
        chk("rd_data_c21", bus.rsp_data, 8'h96);
        bus.rsp_ready = 1'b1;
        step(1);
        bus.rsp_ready = 1'b0;
        chk("rd_done_valid", bus.rsp_valid, 0);
        chk("rd_done_ready", bus.cmd_ready, 1);

        // Contention: bench holds the net high against driven zeros.
        tb_en = 1'b1; tb_val = 1'b1;
        conf_seen = 0;
        send(0, 8'h00);
        step(10);
        chk("cf_all_pulses", conf_seen, 8);
        chk("cf_sticky", conflict_sts, 1);
        conf_seen = 0;
        send(0, 8'hA5);
        chk("cf_sts_cleared", conflict_sts, 0);
        step(10);
        chk("cf_zero_bits", conf_seen, 4);
        chk("cf_sticky2", conflict_sts, 1);
        tb_en = 1'b0;

        // Read with a stalled response; cmd_valid while busy must be ignored.
        send(1, 8'hC3);
        step(10);
        drive_pattern(8'h5A);
        step(2);
        bus.cmd_valid = 1'b1; bus.cmd_rd = 1'b0; bus.cmd_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", bus.rsp_data, 8'h5A);
            chk("stall_valid", bus.rsp_valid, 1);
            step(1);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step(1);
        bus.rsp_ready = 1'b0;
        chk("stall_release_valid", bus.rsp_valid, 0);
        chk("stall_release_ready", bus.cmd_ready, 1);

        // Asynchronous reset in the middle of a drive burst.
        send(0, 8'hF0);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_io_oe", io_oe, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        chk("arst_conflict_sts", conflict_sts, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        send(0, 8'h81);
        chk("post_rst_b7", io, 1);
        step(1);
        chk("post_rst_b6", io, 0);
        step(10);

        // Held cmd_valid: second write accepted at the edge ending cycle 11.
        bus.cmd_valid = 1'b1; bus.cmd_rd = 1'b0; bus.cmd_data = 8'h01;
        step(1);
        bus.cmd_data = 8'h02;
        step(10);
        chk("b2b_idle_c11", bus.cmd_ready, 1);
        step(1);
        bus.cmd_valid = 1'b0;
        chk("b2b_oe_c12", io_oe, 1);
        chk("b2b_bit_c12", io, 0);
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
